// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap controller for the single-cycle
// RV32/RV64 core.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   valid           an instruction is executing this cycle
//   pc              PC of the executing instruction
//   csr_op          000 none, 001 RW, 010 RS, 011 RC, 100 ECALL, 101 MRET,
//                   110 EBREAK, 111 reserved (treated as none)
//   csr_addr        CSR address
//   csr_wd          CSR operand (rs1 or zero-extended immediate)
//   instret         instruction retires this cycle
//   irq_timer       machine timer interrupt, level
//   csr_rd          old CSR value (0 on illegal access), combinational
//   trap_taken      trap entered this cycle
//   pc_redirect     trap or MRET this cycle
//   pc_out          redirect target (mtvec base or mepc)
module csr_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wd,
  input  logic            instret,
  input  logic            irq_timer,
  output logic [XLEN-1:0] csr_rd,
  output logic            trap_taken,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_out
);

  typedef enum logic [2:0] {
    OP_NONE   = 3'b000,
    OP_RW     = 3'b001,
    OP_RS     = 3'b010,
    OP_RC     = 3'b011,
    OP_ECALL  = 3'b100,
    OP_MRET   = 3'b101,
    OP_EBREAK = 3'b110,
    OP_RSVD   = 3'b111
  } csr_op_e;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  // Counters are viewed through a 2*XLEN window so the low/high halves are
  // plain slices regardless of CNT_W.
  localparam int unsigned     PW         = 2 * XLEN;
  localparam bit              HAS_H      = (XLEN == 32);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic             mst_mie_q, mst_mie_d;
  logic             mst_mpie_q, mst_mpie_d;
  logic             mtie_q, mtie_d;
  logic [XLEN-1:0]  mtvec_q, mtvec_d;
  logic [XLEN-1:0]  mscratch_q, mscratch_d;
  logic [XLEN-1:0]  mepc_q, mepc_d;
  logic [XLEN-1:0]  mcause_q, mcause_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;

  logic [XLEN-1:0] mtvec_rd, mepc_rd;
  logic [PW-1:0]   cyc_w, ins_w, cyc_nw, ins_nw;
  logic [XLEN-1:0] rdata, wval, cause;
  logic            addr_ok, addr_ro, is_csr, illegal, irq_pend;
  logic            trap, do_mret, do_wr;

  // Alignment bits of mtvec/mepc are stored but always read back as zero.
  assign mtvec_rd = mtvec_q & ALIGN_MASK;
  assign mepc_rd  = mepc_q & ALIGN_MASK;
  assign cyc_w    = PW'(mcycle_q);
  assign ins_w    = PW'(minstret_q);

  always_comb begin
    rdata   = '0;
    addr_ok = 1'b1;
    addr_ro = 1'b0;
    case (csr_addr)
      A_MSTATUS: begin
        rdata[12:11] = 2'b11;
        rdata[7]     = mst_mpie_q;
        rdata[3]     = mst_mie_q;
      end
      A_MIE:      rdata[7] = mtie_q;
      A_MTVEC:    rdata = mtvec_rd;
      A_MSCRATCH: rdata = mscratch_q;
      A_MEPC:     rdata = mepc_rd;
      A_MCAUSE:   rdata = mcause_q;
      A_MIP: begin
        rdata[7] = irq_timer;
        addr_ro  = 1'b1;
      end
      A_MCYCLE:   rdata = cyc_w[XLEN-1:0];
      A_MINSTRET: rdata = ins_w[XLEN-1:0];
      A_MCYCLEH: begin
        if (HAS_H) rdata = cyc_w[PW-1:XLEN];
        else       addr_ok = 1'b0;
      end
      A_MINSTRETH: begin
        if (HAS_H) rdata = ins_w[PW-1:XLEN];
        else       addr_ok = 1'b0;
      end
      A_MHARTID:  addr_ro = 1'b1;
      default:    addr_ok = 1'b0;
    endcase
  end

  assign is_csr   = (op == OP_RW) || (op == OP_RS) || (op == OP_RC);
  assign illegal  = is_csr && (!addr_ok || addr_ro);
  assign irq_pend = irq_timer && mtie_q && mst_mie_q;
  assign csr_rd   = illegal ? '0 : rdata;

  always_comb begin
    case (op)
      OP_RW:   wval = csr_wd;
      OP_RS:   wval = rdata | csr_wd;
      OP_RC:   wval = rdata & ~csr_wd;
      default: wval = rdata;
    endcase
  end

  // Priority: interrupt > illegal > ECALL/EBREAK > MRET > CSR write.
  always_comb begin
    trap    = 1'b0;
    do_mret = 1'b0;
    do_wr   = 1'b0;
    cause   = '0;
    if (valid && !rst) begin
      if (irq_pend) begin
        trap            = 1'b1;
        cause[XLEN-1]   = 1'b1;
        cause[3:0]      = 4'd7;
      end else if (illegal) begin
        trap       = 1'b1;
        cause[3:0] = 4'd2;
      end else if (op == OP_ECALL) begin
        trap       = 1'b1;
        cause[3:0] = 4'd11;
      end else if (op == OP_EBREAK) begin
        trap       = 1'b1;
        cause[3:0] = 4'd3;
      end else if (op == OP_MRET) begin
        do_mret = 1'b1;
      end else if (is_csr) begin
        do_wr = 1'b1;
      end
    end
  end

  assign trap_taken  = trap;
  assign pc_redirect = trap || do_mret;
  assign pc_out      = do_mret ? mepc_rd : mtvec_rd;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    cyc_nw     = cyc_w;
    ins_nw     = ins_w;
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = (instret && !trap) ? minstret_q + CNT_W'(1) : minstret_q;

    if (trap) begin
      mepc_d     = pc;
      mcause_d   = cause;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (do_mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (do_wr) begin
      // A counter write replaces one half and suppresses that cycle's increment.
      case (csr_addr)
        A_MSTATUS: begin
          mst_mie_d  = wval[3];
          mst_mpie_d = wval[7];
        end
        A_MIE:      mtie_d = wval[7];
        A_MTVEC:    mtvec_d = wval;
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d = wval;
        A_MCAUSE:   mcause_d = wval;
        A_MCYCLE: begin
          cyc_nw   = {cyc_w[PW-1:XLEN], wval};
          mcycle_d = cyc_nw[CNT_W-1:0];
        end
        A_MCYCLEH: begin
          cyc_nw   = {wval, cyc_w[XLEN-1:0]};
          mcycle_d = cyc_nw[CNT_W-1:0];
        end
        A_MINSTRET: begin
          ins_nw     = {ins_w[PW-1:XLEN], wval};
          minstret_d = ins_nw[CNT_W-1:0];
        end
        A_MINSTRETH: begin
          ins_nw     = {wval, ins_w[XLEN-1:0]};
          minstret_d = ins_nw[CNT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule
